// File: rtl/exp_selftest_seq.sv
// On-chip sweep driver for the exponent engines: resets both, pulses go, times
// each engine's done, and checks both results against a built-in vector table.
module exp_selftest_seq #(
   parameter int NUM_TESTS = 8,
   parameter int TIMEOUT   = 1023,
   parameter int RST_CYC   = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   output logic             dut_rst_o,
   output logic             go_o,
   output logic [7:0]       a_o,
   output logic [7:0]       n_o,
   input  logic [15:0]      res_norm_i,
   input  logic [15:0]      res_opt_i,
   input  logic             done_norm_i,
   input  logic             done_opt_i,
   output logic             busy_o,
   output logic [2:0]       idx_o,
   output logic [CNT_W-1:0] cyc_norm_o,
   output logic [CNT_W-1:0] cyc_opt_o,
   output logic             vec_pass_o,
   output logic             vec_fail_o,
   output logic [3:0]       fail_cnt_o,
   output logic             sweep_done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRST, S_SETTLE, S_GO, S_WAIT, S_CHECK, S_FINISH
   } state_t;

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  n;
      logic [15:0] exp_val;
   } vec_t;

   localparam vec_t VEC_TABLE [8] = '{
      '{8'd3,  8'd4,  16'd81},
      '{8'd5,  8'd5,  16'd3125},
      '{8'd2,  8'd15, 16'd32768},
      '{8'd9,  8'd4,  16'd6561},
      '{8'd7,  8'd5,  16'd16807},
      '{8'd2,  8'd14, 16'd16384},
      '{8'd11, 8'd4,  16'd14641},
      '{8'd13, 8'd3,  16'd2197}
   };

   state_t           state;
   logic [7:0]       rst_cnt;
   logic [CNT_W-1:0] cnt;
   logic             lat_norm, lat_opt;
   logic [15:0]      res_norm_q, res_opt_q;

   logic [CNT_W-1:0] cnt_inc;
   logic             lat_norm_nx, lat_opt_nx;
   logic [15:0]      res_norm_nx, res_opt_nx;
   logic             timed_out, vec_ok;
   logic [2:0]       idx_nx;

   // Pass/fail is resolved on the last WAIT cycle so the registered pulse lines
   // up with the CHECK state instead of trailing it by one cycle.
   always_comb begin
      cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      lat_norm_nx = lat_norm | done_norm_i;
      lat_opt_nx  = lat_opt  | done_opt_i;
      res_norm_nx = lat_norm ? res_norm_q : res_norm_i;
      res_opt_nx  = lat_opt  ? res_opt_q  : res_opt_i;
      timed_out   = cnt_inc >= CNT_W'(TIMEOUT);
      vec_ok      = lat_norm_nx && lat_opt_nx && (res_norm_nx == res_opt_nx) &&
                    (res_norm_nx == VEC_TABLE[idx_o].exp_val);
      idx_nx      = idx_o + 3'd1;
   end

   always_ff @(posedge clk) begin
      // NOTE: every register, including the captured results, is cleared so an
      // aborted sweep leaves no partial status behind.
      if (!rst) begin
         state        <= S_IDLE;
         rst_cnt      <= '0;
         cnt          <= '0;
         lat_norm     <= 1'b0;
         lat_opt      <= 1'b0;
         res_norm_q   <= '0;
         res_opt_q    <= '0;
         dut_rst_o    <= 1'b1;
         go_o         <= 1'b0;
         a_o          <= '0;
         n_o          <= '0;
         busy_o       <= 1'b0;
         idx_o        <= '0;
         cyc_norm_o   <= '0;
         cyc_opt_o    <= '0;
         vec_pass_o   <= 1'b0;
         vec_fail_o   <= 1'b0;
         fail_cnt_o   <= '0;
         sweep_done_o <= 1'b0;
      end else begin
         // NOTE: single-cycle strobes default low here and are raised only in the
         // state that owns them, which keeps them exactly one cycle wide.
         go_o       <= 1'b0;
         vec_pass_o <= 1'b0;
         vec_fail_o <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state        <= S_DRST;
                  busy_o       <= 1'b1;
                  idx_o        <= '0;
                  fail_cnt_o   <= '0;
                  sweep_done_o <= 1'b0;
                  dut_rst_o    <= 1'b0;
                  rst_cnt      <= '0;
                  a_o          <= VEC_TABLE[0].a;
                  n_o          <= VEC_TABLE[0].n;
               end
            end

            S_DRST: begin
               if (rst_cnt == 8'(RST_CYC - 1)) begin
                  dut_rst_o <= 1'b1;
                  state     <= S_SETTLE;
               end else begin
                  rst_cnt <= rst_cnt + 8'd1;
               end
            end

            S_SETTLE: begin
               go_o     <= 1'b1;
               cnt      <= '0;
               lat_norm <= 1'b0;
               lat_opt  <= 1'b0;
               state    <= S_GO;
            end

            S_GO: state <= S_WAIT;

            S_WAIT: begin
               cnt <= cnt_inc;
               if (done_norm_i && !lat_norm) begin
                  lat_norm   <= 1'b1;
                  res_norm_q <= res_norm_i;
                  cyc_norm_o <= cnt_inc;
               end
               if (done_opt_i && !lat_opt) begin
                  lat_opt   <= 1'b1;
                  res_opt_q <= res_opt_i;
                  cyc_opt_o <= cnt_inc;
               end
               if ((lat_norm_nx && lat_opt_nx) || timed_out) begin
                  state <= S_CHECK;
                  if (!lat_norm_nx) cyc_norm_o <= '1;
                  if (!lat_opt_nx)  cyc_opt_o  <= '1;
                  if (vec_ok) begin
                     vec_pass_o <= 1'b1;
                  end else begin
                     vec_fail_o <= 1'b1;
                     fail_cnt_o <= (fail_cnt_o == 4'hF) ? fail_cnt_o : fail_cnt_o + 4'd1;
                  end
               end
            end

            S_CHECK: begin
               if (idx_o == 3'(NUM_TESTS - 1)) begin
                  busy_o       <= 1'b0;
                  sweep_done_o <= 1'b1;
                  state        <= S_FINISH;
               end else begin
                  idx_o     <= idx_nx;
                  dut_rst_o <= 1'b0;
                  rst_cnt   <= '0;
                  a_o       <= VEC_TABLE[idx_nx].a;
                  n_o       <= VEC_TABLE[idx_nx].n;
                  state     <= S_DRST;
               end
            end

            S_FINISH: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exp_selftest_seq.sv
// Scoreboard bench for exp_selftest_seq: behavioural engines with configurable
// latency/faults, expected per-vector reports queued at stimulus time.
module tb_exp_selftest_seq;

   localparam int NUM_TESTS = 8;
   localparam int TIMEOUT   = 1023;
   localparam int RST_CYC   = 2;
   localparam int CNT_W     = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start_i = 1'b0;
   logic             dut_rst_o, go_o;
   logic [7:0]       a_o, n_o;
   logic [15:0]      res_norm_i = '0, res_opt_i = '0;
   logic             done_norm_i = 1'b0, done_opt_i = 1'b0;
   logic             busy_o;
   logic [2:0]       idx_o;
   logic [CNT_W-1:0] cyc_norm_o, cyc_opt_o;
   logic             vec_pass_o, vec_fail_o;
   logic [3:0]       fail_cnt_o;
   logic             sweep_done_o;

   exp_selftest_seq #(
      .NUM_TESTS(NUM_TESTS), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .dut_rst_o(dut_rst_o), .go_o(go_o), .a_o(a_o), .n_o(n_o),
      .res_norm_i(res_norm_i), .res_opt_i(res_opt_i),
      .done_norm_i(done_norm_i), .done_opt_i(done_opt_i),
      .busy_o(busy_o), .idx_o(idx_o),
      .cyc_norm_o(cyc_norm_o), .cyc_opt_o(cyc_opt_o),
      .vec_pass_o(vec_pass_o), .vec_fail_o(vec_fail_o),
      .fail_cnt_o(fail_cnt_o), .sweep_done_o(sweep_done_o)
   );

   always #5 clk = ~clk;

   logic [7:0]  tab_a [8] = '{8'd3, 8'd5, 8'd2, 8'd9, 8'd7, 8'd2, 8'd11, 8'd13};
   logic [7:0]  tab_n [8] = '{8'd4, 8'd5, 8'd15, 8'd4, 8'd5, 8'd14, 8'd4, 8'd3};

   typedef struct {
      logic        pass;
      logic [2:0]  idx;
      logic [15:0] cn;
      logic [15:0] co;
      logic [3:0]  fc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   pass_seen = 0;

   // engine model controls
   bit same4 = 0;
   bit bad_opt_v0 = 0;
   bit hang_norm_v3 = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h @%0t", name, actual, required, $time);
      end
   endtask

   function automatic logic [15:0] pw(input logic [7:0] a, input logic [7:0] n);
      logic [15:0] r = 16'd1;
      for (int i = 0; i < int'(n); i++) r = r * 16'(a);
      return r;
   endfunction

   // Behavioural engines: done rises in WAIT cycle `latency` and stays high.
   int  eng_w = 0;
   bit  eng_run = 0;
   int  lat_n, lat_o;
   always @(negedge clk) begin
      if (!rst || dut_rst_o === 1'b0) begin
         eng_run = 0; eng_w = 0;
         done_norm_i = 1'b0; done_opt_i = 1'b0;
         res_norm_i = '0; res_opt_i = '0;
      end else if (go_o === 1'b1) begin
         eng_run = 1; eng_w = 0;
      end else if (eng_run) begin
         eng_w++;
         lat_n = same4 ? 4 : int'(n_o) + 2;
         lat_o = same4 ? 4 : 3;
         if (eng_w >= lat_n && !(hang_norm_v3 && idx_o == 3'd3)) begin
            done_norm_i = 1'b1;
            res_norm_i  = pw(a_o, n_o);
         end
         if (eng_w >= lat_o) begin
            done_opt_i = 1'b1;
            res_opt_i  = pw(a_o, n_o) + ((bad_opt_v0 && idx_o == 3'd0) ? 16'd1 : 16'd0);
         end
      end
   end

   // Scoreboard monitor: one queued expectation per CHECK pulse.
   exp_t e;
   always @(negedge clk) begin
      if (rst && (vec_pass_o === 1'b1 || vec_fail_o === 1'b1)) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_report", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check("vec_idx",      idx_o,                    e.idx);
            check("vec_pass_fail", {vec_pass_o, vec_fail_o}, {e.pass, !e.pass});
            check("vec_cyc_norm", cyc_norm_o,               e.cn);
            check("vec_cyc_opt",  cyc_opt_o,                e.co);
            check("vec_fail_cnt", fail_cnt_o,               e.fc);
            if (vec_pass_o) pass_seen++;
         end
      end
   end

   // Protocol monitor: dut_rst width, go width, operand stability per vector.
   int          low_run = 0, go_run = 0;
   logic [7:0]  cap_a, cap_n;
   bit          cap_valid = 0;
   always @(negedge clk) begin
      if (!rst) begin
         low_run = 0; go_run = 0; cap_valid = 0;
      end else begin
         if (dut_rst_o === 1'b0) begin
            if (low_run == 0) begin
               cap_a = a_o; cap_n = n_o; cap_valid = 1;
               check("drst_a_table", a_o, tab_a[idx_o]);
               check("drst_n_table", n_o, tab_n[idx_o]);
            end
            low_run++;
         end else begin
            if (low_run != 0) check("drst_len", low_run, RST_CYC);
            low_run = 0;
         end
         if (go_o === 1'b1) begin
            go_run++;
         end else begin
            if (go_run != 0) check("go_len", go_run, 1);
            go_run = 0;
         end
         if (cap_valid && busy_o === 1'b1) begin
            check("a_stable", a_o, cap_a);
            check("n_stable", n_o, cap_n);
         end
      end
   end

   task automatic push_exp(input int i, input bit pass, input int cn, input int co, input int fc);
      exp_t x;
      x.pass = pass; x.idx = 3'(i); x.cn = 16'(cn); x.co = 16'(co); x.fc = 4'(fc);
      sb_q.push_back(x);
   endtask

   task automatic pulse_start();
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
   endtask

   task automatic wait_sweep(input string name);
      int n = 0;
      while (sweep_done_o !== 1'b1 && n < 4000) begin
         @(negedge clk); n++;
      end
      check({name, "_sweep_done"}, sweep_done_o, 1'b1);
      check({name, "_busy_low"},   busy_o,       1'b0);
      check({name, "_idx_last"},   idx_o,        3'd7);
      check({name, "_sb_empty"},   32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_go_idx(input logic [2:0] want);
      int n = 0;
      while (!(go_o === 1'b1 && idx_o == want) && n < 2000) begin
         @(negedge clk); n++;
      end
      check("wait_go_seen", go_o, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dut_rst"},    dut_rst_o,    1'b1);
      check({tag, "_go"},         go_o,         1'b0);
      check({tag, "_a"},          a_o,          8'd0);
      check({tag, "_n"},          n_o,          8'd0);
      check({tag, "_busy"},       busy_o,       1'b0);
      check({tag, "_idx"},        idx_o,        3'd0);
      check({tag, "_cyc_norm"},   cyc_norm_o,   16'd0);
      check({tag, "_cyc_opt"},    cyc_opt_o,    16'd0);
      check({tag, "_pass"},       vec_pass_o,   1'b0);
      check({tag, "_fail"},       vec_fail_o,   1'b0);
      check({tag, "_fail_cnt"},   fail_cnt_o,   4'd0);
      check({tag, "_sweep_done"}, sweep_done_o, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;

      // Sweep A: healthy engines, normal latency n+2, opt latency 3.
      for (int i = 0; i < 8; i++) push_exp(i, 1, int'(tab_n[i]) + 2, 3, 0);
      pass_seen = 0;
      pulse_start();
      check("a_busy_after_start", busy_o, 1'b1);
      wait_sweep("a");
      check("a_pass_count", pass_seen, 8);
      check("a_fail_cnt",   fail_cnt_o, 4'd0);
      check("a_last_cyc_norm", cyc_norm_o, 16'd5);
      check("a_last_cyc_opt",  cyc_opt_o,  16'd3);

      // Sweep B: opt engine off by one on vector 0.
      bad_opt_v0 = 1;
      push_exp(0, 0, 6, 3, 1);
      for (int i = 1; i < 8; i++) push_exp(i, 1, int'(tab_n[i]) + 2, 3, 1);
      pass_seen = 0;
      pulse_start();
      wait_sweep("b");
      check("b_pass_count", pass_seen, 7);
      check("b_fail_cnt",   fail_cnt_o, 4'd1);
      bad_opt_v0 = 0;

      // Sweep C: normal engine never finishes vector 3 -> timeout.
      hang_norm_v3 = 1;
      for (int i = 0; i < 3; i++) push_exp(i, 1, int'(tab_n[i]) + 2, 3, 0);
      push_exp(3, 0, 16'hFFFF, 3, 1);
      for (int i = 4; i < 8; i++) push_exp(i, 1, int'(tab_n[i]) + 2, 3, 1);
      pass_seen = 0;
      pulse_start();
      wait_sweep("c");
      check("c_pass_count", pass_seen, 7);
      check("c_fail_cnt",   fail_cnt_o, 4'd1);
      hang_norm_v3 = 0;

      // Sweep D: both engines latency 4; stray start_i during WAIT of vector 2.
      same4 = 1;
      for (int i = 0; i < 8; i++) push_exp(i, 1, 4, 4, 0);
      pass_seen = 0;
      pulse_start();
      wait_go_idx(3'd2);
      pulse_start();
      check("d_busy_after_restart", busy_o, 1'b1);
      check("d_idx_after_restart",  idx_o,  3'd2);
      wait_sweep("d");
      check("d_pass_count", pass_seen, 8);
      same4 = 0;

      // Sweep E: reset asserted in the first WAIT cycle of vector 5.
      for (int i = 0; i < 5; i++) push_exp(i, 1, int'(tab_n[i]) + 2, 3, 0);
      pass_seen = 0;
      pulse_start();
      wait_go_idx(3'd5);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      rst = 1'b1;
      check("e_pass_count", pass_seen, 5);
      check("e_sb_empty",   32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      check("e_idle_busy", busy_o, 1'b0);
      check("e_idle_go",   go_o,   1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
